// File: rtl/control_cmd_router.sv
// Opcode router: matches the first byte of a command against a table and
// forwards the payload to the selected sub-command over an enable/ready/done handshake.
module control_cmd_router #(
    parameter int unsigned NUM_SUBCMDS = 4,
    parameter logic [8*NUM_SUBCMDS-1:0] OPCODE_TABLE = 32'h5A_4C_66_46,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned SEL_W = (NUM_SUBCMDS > 1) ? $clog2(NUM_SUBCMDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [7:0]             data_out,
    output logic [NUM_SUBCMDS-1:0] sub_enable,
    input  logic [NUM_SUBCMDS-1:0] sub_ready_for_data,
    input  logic [NUM_SUBCMDS-1:0] sub_done,
    output logic [NUM_SUBCMDS-1:0] sub_abort,
    output logic [SEL_W-1:0]       active_cmd,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FORWARD   = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [7:0]             data_out_q, data_out_d;
    logic [NUM_SUBCMDS-1:0] sub_enable_q, sub_enable_d;
    logic [NUM_SUBCMDS-1:0] sub_abort_q, sub_abort_d;
    logic                   cmd_done_q, cmd_done_d;
    logic                   error_q, error_d;
    logic                   in_flight_q, in_flight_d;
    logic [7:0]             fwd_cnt_q, fwd_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic                   accept;
    logic                   op_match;
    logic [SEL_W-1:0]       op_idx;
    logic [NUM_SUBCMDS-1:0] sel_onehot;
    logic [TMO_W-1:0]       tmo_inc;

    // One byte in flight at a time, so a sub-command dropping ready on its
    // last byte never sees an extra strobe.
    assign data_ready = reset && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_FORWARD) && sub_ready_for_data[sel_q] && !in_flight_q));
    assign accept     = data_valid && data_ready;
    assign sel_onehot = NUM_SUBCMDS'(1) << sel_q;
    assign tmo_inc    = tmo_q + TMO_W'(1);

    assign data_out   = data_out_q;
    assign sub_enable = sub_enable_q;
    assign sub_abort  = sub_abort_q;
    assign active_cmd = sel_q;
    assign busy       = (state_q != ST_IDLE);
    assign cmd_done   = cmd_done_q;
    assign error      = error_q;

    // Opcode lookup; scanning downward lets the lowest matching index win.
    always_comb begin
        op_match = 1'b0;
        op_idx   = '0;
        for (int i = NUM_SUBCMDS - 1; i >= 0; i--) begin
            if (data_in == OPCODE_TABLE[8*i +: 8]) begin
                op_match = 1'b1;
                op_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        data_out_d   = data_out_q;
        sub_enable_d = '0;
        sub_abort_d  = '0;
        cmd_done_d   = 1'b0;
        error_d      = 1'b0;
        in_flight_d  = 1'b0;
        fwd_cnt_d    = fwd_cnt_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_match) begin
                        sel_d     = op_idx;
                        fwd_cnt_d = 8'd0;
                        tmo_d     = '0;
                        state_d   = ST_FORWARD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_FORWARD: begin
                if (sub_done[sel_q]) begin
                    cmd_done_d = 1'b1;
                    sel_d      = '0;
                    state_d    = ST_IDLE;
                end else if (accept) begin
                    data_out_d   = data_in;
                    sub_enable_d = sel_onehot;
                    in_flight_d  = 1'b1;
                    tmo_d        = '0;
                    if (fwd_cnt_q != 8'hFF) begin
                        fwd_cnt_d = fwd_cnt_q + 8'd1;
                    end
                end else if ((fwd_cnt_q != 8'd0) && !in_flight_q && !sub_ready_for_data[sel_q]) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
                    sub_abort_d = sel_onehot;
                    error_d     = 1'b1;
                    sel_d       = '0;
                    tmo_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (sub_done[sel_q]) begin
                    cmd_done_d = 1'b1;
                    sel_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            data_out_q   <= 8'd0;
            sub_enable_q <= '0;
            sub_abort_q  <= '0;
            cmd_done_q   <= 1'b0;
            error_q      <= 1'b0;
            in_flight_q  <= 1'b0;
            fwd_cnt_q    <= 8'd0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_out_q   <= data_out_d;
            sub_enable_q <= sub_enable_d;
            sub_abort_q  <= sub_abort_d;
            cmd_done_q   <= cmd_done_d;
            error_q      <= error_d;
            in_flight_q  <= in_flight_d;
            fwd_cnt_q    <= fwd_cnt_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_control_cmd_router.sv
// Bench for control_cmd_router: opcode vector table plus scripted multi-cycle
// sequences, with a queue of expected sub-command strobes.
module tb_control_cmd_router;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_out;
    logic [3:0] sub_enable;
    logic [3:0] sub_rfd;
    logic [3:0] sub_done;
    logic [3:0] sub_abort;
    logic [1:0] active_cmd;
    logic       busy;
    logic       cmd_done;
    logic       error;

    control_cmd_router #(
        .NUM_SUBCMDS   (4),
        .OPCODE_TABLE  (32'h5A_4C_66_46),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .data_out          (data_out),
        .sub_enable        (sub_enable),
        .sub_ready_for_data(sub_rfd),
        .sub_done          (sub_done),
        .sub_abort         (sub_abort),
        .active_cmd        (active_cmd),
        .busy              (busy),
        .cmd_done          (cmd_done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] op;
        logic       err;
        logic [1:0] cmd;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_en = -100;
    int   en_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   abort_cnt = 0;
    bit   watch_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; observe outputs 1 time unit after the edge.
    task automatic tick();
        exp_t       e;
        logic [3:0] oh;
        @(posedge clk);
        #1;
        cyc++;
        if (cmd_done) done_cnt++;
        if (error) err_cnt++;
        if (sub_abort != 4'd0) abort_cnt++;
        if (watch_busy) check("busy_hold", busy, 1);
        if (sub_enable != 4'd0) begin
            en_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_enable", sub_enable, 0);
            end else begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.idx;
                check("enable_onehot", sub_enable, oh);
                check("enable_data", data_out, e.data);
            end
            check("enable_spacing", (cyc - last_en) >= 2, 1);
            last_en = cyc;
        end
    endtask

    // Offer a byte until accepted (bounded); queue the strobe it should produce.
    task automatic send_byte(input logic [7:0] b, input bit fwd, input logic [1:0] idx);
        exp_t e;
        int   n;
        n = 0;
        data_in    = b;
        data_valid = 1'b1;
        #1;
        while (!data_ready && n < 50) begin
            tick();
            n++;
        end
        if (!data_ready) begin
            check("ready_wait_expired", 0, 1);
            data_valid = 1'b0;
            return;
        end
        if (fwd) begin
            e.idx  = idx;
            e.data = b;
            sb.push_back(e);
        end
        tick();
        data_valid = 1'b0;
        if (fwd) check("strobe_latency", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt[8];
        int   e0, d0, n0, a0;
        logic [1:0] nxt;
        logic [3:0] fo;

        vt[0] = '{8'h00, 1'b1, 2'd0};
        vt[1] = '{8'h5A, 1'b0, 2'd3};
        vt[2] = '{8'h46, 1'b0, 2'd0};
        vt[3] = '{8'h66, 1'b0, 2'd1};
        vt[4] = '{8'h4C, 1'b0, 2'd2};
        vt[5] = '{8'hFF, 1'b1, 2'd0};
        vt[6] = '{8'h47, 1'b1, 2'd0};
        vt[7] = '{8'h4D, 1'b1, 2'd0};

        rst_n      = 1'b0;
        data_in    = 8'd0;
        data_valid = 1'b1;
        sub_rfd    = 4'd0;
        sub_done   = 4'd0;
        #2;
        check("reset_data_ready", data_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_outputs", {data_out, sub_enable, sub_abort, active_cmd, cmd_done, error}, 0);
        data_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_data_ready", data_ready, 1);

        // Opcode table: error for unknown bytes, selection for known ones.
        for (int i = 0; i < 8; i++) begin
            send_byte(vt[i].op, 1'b0, 2'd0);
            check("vec_error", error, vt[i].err);
            check("vec_busy", busy, !vt[i].err);
            if (!vt[i].err) begin
                check("vec_active", active_cmd, vt[i].cmd);
                nxt      = vt[i].cmd + 2'd1;
                fo       = 4'b0001 << nxt;
                sub_done = fo;
                tick();
                sub_done = 4'd0;
                check("vec_foreign_done", cmd_done, 0);
                check("vec_foreign_busy", busy, 1);
                sub_done = 4'b0001 << vt[i].cmd;
                tick();
                sub_done = 4'd0;
                check("vec_done", cmd_done, 1);
                check("vec_done_idle", {busy, active_cmd}, 0);
            end else begin
                tick();
                check("vec_error_pulse", error, 0);
            end
        end
        check("no_stray_enables", en_cnt, 0);

        // Fill-rect: 7 payload bytes, ready drops after the 7th, done 5 cycles later.
        d0 = done_cnt;
        n0 = en_cnt;
        sub_rfd = 4'b0001;
        send_byte(8'h46, 1'b0, 2'd0);
        check("fill_active", active_cmd, 0);
        watch_busy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            send_byte(8'h10 + 8'(k * 37), 1'b1, 2'd0);
        end
        sub_rfd = 4'd0;
        for (int k = 0; k < 5; k++) tick();
        watch_busy = 1'b0;
        sub_done = 4'b0001;
        tick();
        sub_done = 4'd0;
        check("fill_cmd_done", cmd_done, 1);
        check("fill_idle_ready", data_ready, 1);
        tick();
        check("fill_done_count", done_cnt - d0, 1);
        check("fill_enable_count", en_cnt - n0, 7);

        // Backpressure: sub 2 not ready for 10 cycles.
        sub_rfd = 4'b1011;
        send_byte(8'h4C, 1'b0, 2'd0);
        check("bp_active", active_cmd, 2);
        n0 = en_cnt;
        data_in    = 8'hA5;
        data_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_ready_low", data_ready, 0);
            check("bp_forward", {busy, active_cmd}, 3'b110);
        end
        check("bp_no_strobe", en_cnt - n0, 0);
        data_valid = 1'b0;
        sub_rfd = 4'b1111;
        send_byte(8'hA5, 1'b1, 2'd2);
        sub_rfd = 4'b1011;
        tick();
        tick();
        sub_done = 4'b0100;
        tick();
        sub_done = 4'd0;
        check("bp_cmd_done", cmd_done, 1);

        // Timeout: one byte to sub 1, then 16 idle cycles.
        d0 = done_cnt;
        a0 = abort_cnt;
        sub_rfd = 4'b0010;
        send_byte(8'h66, 1'b0, 2'd0);
        send_byte(8'h77, 1'b1, 2'd1);
        watch_busy = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        watch_busy = 1'b0;
        check("tmo_no_early_abort", abort_cnt - a0, 0);
        tick();
        check("tmo_abort", sub_abort, 4'b0010);
        check("tmo_error", error, 1);
        check("tmo_idle", {busy, active_cmd}, 0);
        tick();
        check("tmo_pulse_width", {sub_abort, error}, 0);
        check("tmo_no_cmd_done", done_cnt - d0, 0);

        // Foreign done while waiting on sub 0; no timeout in WAIT_DONE.
        sub_rfd = 4'b0001;
        send_byte(8'h46, 1'b0, 2'd0);
        send_byte(8'h33, 1'b1, 2'd0);
        sub_rfd = 4'd0;
        tick();
        tick();
        d0 = done_cnt;
        e0 = err_cnt;
        sub_done = 4'b1000;
        tick();
        sub_done = 4'd0;
        watch_busy = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        watch_busy = 1'b0;
        check("wd_foreign_no_done", done_cnt - d0, 0);
        check("wd_no_timeout", err_cnt - e0, 0);
        sub_done = 4'b0001;
        tick();
        sub_done = 4'd0;
        check("wd_cmd_done", cmd_done, 1);

        // Async reset mid-FORWARD, right after a strobe.
        sub_rfd = 4'b0001;
        send_byte(8'h46, 1'b0, 2'd0);
        send_byte(8'h99, 1'b1, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", data_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_outputs", {data_out, sub_enable, sub_abort, active_cmd, cmd_done, error}, 0);
        tick();
        rst_n = 1'b1;
        send_byte(8'h46, 1'b0, 2'd0);
        check("arst_reselect", {busy, active_cmd}, 3'b100);
        sub_done = 4'b0001;
        tick();
        sub_done = 4'd0;
        check("arst_cmd_done", cmd_done, 1);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
